// File: rtl/serial_add_sequencer.sv
// Bit-serial adder shared by two requesters: round-robin grant, LSB-first stepping
// of one full-adder cell over WIDTH cycles, result and carry returned with a per-requester ack.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             busy,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Handshake: reqN is a level held by the client until ackN; ackN is a
    // one-cycle pulse during which result/cout already carry that client's sum.
    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb, sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             gid, last_id;
    logic             grant, grant_id;
    logic             fa_s, fa_co;
    logic             ab_x, ab_a, xc_a;

    // Shared single-bit full-adder cell built from primitive gates.
    xor g_x1 (ab_x, opa[0], opb[0]);
    xor g_x2 (fa_s, ab_x, carry);
    and g_a1 (ab_a, opa[0], opb[0]);
    and g_a2 (xc_a, ab_x, carry);
    or  g_o1 (fa_co, ab_a, xc_a);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_id  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    grant    = 1'b1;
                    grant_id = ~last_id;
                end else if (req0 || req1) begin
                    grant    = 1'b1;
                    grant_id = req1;
                end
                if (grant) state_nxt = RUN;
            end
            RUN:     if (cnt == LAST_BIT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa     <= '0;
            opb     <= '0;
            sum_sr  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            gid     <= 1'b0;
            last_id <= 1'b1;
            result  <= '0;
            cout    <= 1'b0;
        end else begin
            if (grant) begin
                opa    <= grant_id ? a1 : a0;
                opb    <= grant_id ? b1 : b0;
                sum_sr <= '0;
                carry  <= 1'b0;
                cnt    <= '0;
                gid    <= grant_id;
            end
            if (state == RUN) begin
                opa    <= opa >> 1;
                opb    <= opb >> 1;
                sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
                carry  <= fa_co;
                cnt    <= cnt + 1'b1;
                // Output registers take the finished sum on the final bit so they
                // are already valid during the DONE cycle alongside the ack.
                if (cnt == LAST_BIT) begin
                    result <= {fa_s, sum_sr[WIDTH-1:1]};
                    cout   <= fa_co;
                end
            end
            if (state == DONE) last_id <= gid;
        end
    end

    assign busy = (state != IDLE);
    assign ack0 = (state == DONE) && !gid;
    assign ack1 = (state == DONE) && gid;

endmodule
